pipe_stall_ctrl: RTL and testbench

Parametrised pipeline control unit replacing the fixed 6-bit stall controller of the 5-stage core. Resolves per-stage stall requests into a stall/bubble vector for NUM_STAGES stages (index 0 = PC, ascending toward WB). Adds a timed multi-cycle hold engine for iterative units (div/mul) and an exception flush path with redirect PC. Sits beside the pipeline stages in mycpu_core; all stages consume its stall, bubble and flush vectors.

---
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble/flush controller with a timed hold engine for iterative units.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int NUM_STAGES = 6,
    parameter int PC_WIDTH   = 32,
    parameter int HOLD_WIDTH = 6,
    parameter int CNT_WIDTH  = 32,
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  hold_req,
    input  logic [SW-1:0]         hold_stage,
    input  logic [HOLD_WIDTH-1:0] hold_cycles,
    input  logic                  excp_valid,
    input  logic [SW-1:0]         excp_stage,
    input  logic [PC_WIDTH-1:0]   excp_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  new_pc_valid,
    output logic [PC_WIDTH-1:0]   new_pc,
    output logic                  hold_busy,
    output logic                  hold_done,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    typedef enum logic {IDLE, HOLD} hold_state_e;

    hold_state_e           state_q, state_d;
    logic [SW-1:0]         hold_stage_q, hold_stage_d;
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                  hold_done_q, hold_done_d;
    logic [NUM_STAGES-1:0] flush_q, flush_d;
    logic                  new_pc_valid_q, new_pc_valid_d;
    logic [PC_WIDTH-1:0]   new_pc_q, new_pc_d;

    logic [NUM_STAGES-1:0] hold_mask, req, stall_c, bubble_c;
    logic                  acc;

    always_comb begin
        hold_mask = '0;
        if (state_q == HOLD) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                hold_mask[i] = (hold_stage_q == SW'(i));
            end
        end
        req = stallreq | hold_mask;
    end

    // Every stage at or below the highest requester stalls; the one above it takes a bubble.
    always_comb begin
        stall_c  = '0;
        bubble_c = '0;
        acc      = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc        = acc | req[i];
            stall_c[i] = acc;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble_c[i] = stall_c[i-1] & ~stall_c[i];
        end
        if (new_pc_valid_q) begin
            stall_c  = '0;
            bubble_c = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_stage_d   = hold_stage_q;
        hold_cnt_d     = hold_cnt_q;
        hold_done_d    = 1'b0;
        new_pc_valid_d = excp_valid;
        new_pc_d       = excp_valid ? excp_pc : new_pc_q;
        for (int i = 0; i < NUM_STAGES; i++) begin
            flush_d[i] = excp_valid && (excp_stage >= SW'(i));
        end
        case (state_q)
            IDLE: begin
                if (hold_req && (hold_cycles != '0) && !excp_valid) begin
                    state_d      = HOLD;
                    hold_stage_d = hold_stage;
                    hold_cnt_d   = hold_cycles;
                end
            end
            HOLD: begin
                if (excp_valid) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_WIDTH'(1)) begin
                    state_d     = IDLE;
                    hold_done_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_stage_q   <= '0;
            hold_cnt_q     <= '0;
            hold_done_q    <= 1'b0;
            flush_q        <= '0;
            new_pc_valid_q <= 1'b0;
            new_pc_q       <= '0;
        end else begin
            state_q        <= state_d;
            hold_stage_q   <= hold_stage_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_done_q    <= hold_done_d;
            flush_q        <= flush_d;
            new_pc_valid_q <= new_pc_valid_d;
            new_pc_q       <= new_pc_d;
        end
    end

    assign stall        = stall_c;
    assign bubble       = bubble_c;
    assign flush        = flush_q;
    assign new_pc_valid = new_pc_valid_q;
    assign new_pc       = new_pc_q;
    assign hold_busy    = (state_q == HOLD);
    assign hold_done    = hold_done_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (new_pc_valid_q && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed steps followed by random traffic,
// all compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int N  = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  stallreq = '0;
    logic          hold_req = 1'b0;
    logic [SW-1:0] hold_stage = '0;
    logic [5:0]    hold_cycles = '0;
    logic          excp_valid = 1'b0;
    logic [SW-1:0] excp_stage = '0;
    logic [31:0]   excp_pc = '0;
    logic [N-1:0]  stall, bubble, flush;
    logic          new_pc_valid, hold_busy, hold_done;
    logic [31:0]   new_pc, stall_cnt, flush_cnt;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .hold_req(hold_req),
        .hold_stage(hold_stage), .hold_cycles(hold_cycles), .excp_valid(excp_valid),
        .excp_stage(excp_stage), .excp_pc(excp_pc), .stall(stall), .bubble(bubble),
        .flush(flush), .new_pc_valid(new_pc_valid), .new_pc(new_pc),
        .hold_busy(hold_busy), .hold_done(hold_done), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;
    bit checking  = 1'b0;

    // Behavioural model state
    int          m_hold_rem = 0;
    int          m_hold_stage = 0;
    bit          m_done = 0;
    bit          m_fl_pend = 0;
    int          m_fl_stage = 0;
    logic [31:0] m_new_pc = '0;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle(input logic [N-1:0] sr, input bit hr, input int hs, input int hc,
                            input bit ev, input int es, input logic [31:0] ep, input bit r);
        int          h;
        logic [N-1:0] rq, e_stall, e_bubble, e_flush;
        @(negedge clk);
        stallreq = sr; hold_req = hr; hold_stage = SW'(hs); hold_cycles = 6'(hc);
        excp_valid = ev; excp_stage = SW'(es); excp_pc = ep; rst = r;
        #1;
        rq = sr;
        if (m_hold_rem > 0 && m_hold_stage < N) rq[m_hold_stage] = 1'b1;
        h = -1;
        for (int i = 0; i < N; i++) if (rq[i]) h = i;
        e_stall = '0; e_bubble = '0; e_flush = '0;
        if (!m_fl_pend && h >= 0) begin
            for (int i = 0; i <= h; i++) e_stall[i] = 1'b1;
            if (h + 1 < N) e_bubble[h+1] = 1'b1;
        end
        if (m_fl_pend) for (int i = 0; i < N; i++) if (i <= m_fl_stage) e_flush[i] = 1'b1;
        if (checking) begin
            chk("stall", 64'(stall), 64'(e_stall));
            chk("bubble", 64'(bubble), 64'(e_bubble));
            chk("flush", 64'(flush), 64'(e_flush));
            chk("new_pc_valid", 64'(new_pc_valid), 64'(m_fl_pend));
            chk("new_pc", 64'(new_pc), 64'(m_new_pc));
            chk("hold_busy", 64'(hold_busy), 64'(m_hold_rem > 0));
            chk("hold_done", 64'(hold_done), 64'(m_done));
`ifdef PIPE_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
            chk("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
`else
            chk("stall_cnt", 64'(stall_cnt), 64'(0));
            chk("flush_cnt", 64'(flush_cnt), 64'(0));
`endif
        end
        // Advance the model across the coming rising edge
        if (r) begin
            m_hold_rem = 0; m_hold_stage = 0; m_done = 0; m_fl_pend = 0;
            m_fl_stage = 0; m_new_pc = '0; m_scnt = '0; m_fcnt = '0;
        end else begin
            if (e_stall[0] && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (m_fl_pend && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            m_done = 0;
            if (m_hold_rem > 0) begin
                if (ev) m_hold_rem = 0;
                else begin
                    m_hold_rem--;
                    if (m_hold_rem == 0) m_done = 1;
                end
            end else if (hr && hc != 0 && !ev) begin
                m_hold_rem = hc; m_hold_stage = hs;
            end
            m_fl_pend = ev;
            if (ev) begin m_fl_stage = es; m_new_pc = ep; end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle('0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        do_cycle('0, 0, 0, 0, 0, 0, '0, 1);
        checking = 1'b1;
        idle(1);

        // Single EX request, then release
        do_cycle(6'b001000, 0, 0, 0, 0, 0, '0, 0);
        chk("ex_stall", 64'(stall), 64'(6'b001111));
        chk("ex_bubble", 64'(bubble), 64'(6'b010000));
        idle(1);
        chk("rel_stall", 64'(stall), 64'(0));

        // Highest index wins; WB request leaves no bubble
        do_cycle(6'b000101, 0, 0, 0, 0, 0, '0, 0);
        chk("multi_stall", 64'(stall), 64'(6'b000111));
        chk("multi_bubble", 64'(bubble), 64'(6'b001000));
        do_cycle(6'b100000, 0, 0, 0, 0, 0, '0, 0);
        chk("wb_bubble", 64'(bubble), 64'(0));

        // Timed hold of 4 cycles at stage 3
        do_cycle('0, 1, 3, 4, 0, 0, '0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("hold_busy_on", 64'(hold_busy), 64'(1));
            chk("hold_stall", 64'(stall), 64'(6'b001111));
        end
        idle(1);
        chk("hold_busy_off", 64'(hold_busy), 64'(0));
        chk("hold_done_pulse", 64'(hold_done), 64'(1));
        idle(1);
        chk("hold_done_clear", 64'(hold_done), 64'(0));

        // Zero-length hold is ignored
        do_cycle('0, 1, 2, 0, 0, 0, '0, 0);
        idle(1);
        chk("hold0_busy", 64'(hold_busy), 64'(0));

        // Exception during a hold aborts it
        do_cycle('0, 1, 3, 10, 0, 0, '0, 0);
        idle(2);
        do_cycle(6'b000010, 0, 0, 0, 1, 4, 32'hBFC00380, 0);
        do_cycle(6'b000010, 0, 0, 0, 0, 0, '0, 0);
        chk("excp_flush", 64'(flush), 64'(6'b011111));
        chk("excp_pc", 64'(new_pc), 64'(32'hBFC00380));
        chk("excp_stall", 64'(stall), 64'(0));
        chk("excp_abort", 64'(hold_busy), 64'(0));
        idle(2);

        // Back-to-back exceptions, each with its own PC
        do_cycle('0, 0, 0, 0, 1, 1, 32'h1000, 0);
        do_cycle('0, 0, 0, 0, 1, 2, 32'h2000, 0);
        chk("b2b_pc1", 64'(new_pc), 64'(32'h1000));
        idle(1);
        chk("b2b_pc2", 64'(new_pc), 64'(32'h2000));
        idle(1);

        // Exception beats a simultaneous hold request
        do_cycle('0, 1, 2, 5, 1, 0, 32'h3000, 0);
        idle(2);
        chk("excp_wins", 64'(hold_busy), 64'(0));

        // Reset in the middle of a hold
        do_cycle('0, 1, 1, 8, 0, 0, '0, 0);
        idle(2);
        do_cycle('0, 0, 0, 0, 0, 0, '0, 1);
        idle(1);
        chk("rst_busy", 64'(hold_busy), 64'(0));
        chk("rst_newpc", 64'(new_pc), 64'(0));

        // 10 stalled cycles and 2 flushes from reset
        do_cycle('0, 0, 0, 0, 0, 0, '0, 1);
        for (int k = 0; k < 10; k++) do_cycle(6'b000001, 0, 0, 0, 0, 0, '0, 0);
        do_cycle('0, 0, 0, 0, 1, 0, 32'h40, 0);
        do_cycle('0, 0, 0, 0, 1, 0, 32'h44, 0);
        idle(2);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall", 64'(stall_cnt), 64'(10));
        chk("perf_flush", 64'(flush_cnt), 64'(2));
`else
        chk("perf_stall", 64'(stall_cnt), 64'(0));
        chk("perf_flush", 64'(flush_cnt), 64'(0));
`endif

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] sr;
            sr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            do_cycle(sr, $urandom_range(0, 9) == 0, $urandom_range(0, N - 1),
                     $urandom_range(0, 9), $urandom_range(0, 19) == 0,
                     $urandom_range(0, 7), $urandom, $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
